gt_link_sequencer: RTL and testbench
====================================

Name: gt_link_sequencer

Overview:
- Supervises GT transceiver bring-up and link health for the SFP+ lanes in the TX user-clock domain.
- Generates the user-clock-active qualifier and tracks TX/RX reset completion.
- Debounces per-lane 64b/66b block lock and high-BER status, and issues a shared RX datapath reset to the transceiver wizard when lock is not reached or is lost.
- Sits between the transceiver wizard reset/status signals and the PHY/core; its lane_up outputs qualify traffic.

Parameters:
- LANES, 2, number of transceiver lanes sharing one RX datapath reset.
- SYNC_STAGES, 2, flip-flop stages on every asynchronous input (minimum 2).
- ACTIVE_DELAY, 8, gt_txusrclk cycles after reset before userclk_tx_active asserts (1..255).
- DEBOUNCE, 1024, consecutive cycles needed to declare a lane good or bad (1..65535).
- LOCK_TIMEOUT, 1048576, cycles allowed in LOCK_WAIT before retraining (counter width is clog2(LOCK_TIMEOUT+1)).
- RST_PULSE, 16, width of the reset_rx_datapath_out pulse in cycles (1..255).

Ports:
- gt_txusrclk  input  1  clock.
- gt_tx_reset  input  1  asynchronous, active-high reset.
- reset_tx_done_in  input  1  wizard TX reset done; asynchronous.
- reset_rx_done_in  input  1  wizard RX reset done; asynchronous.
- rx_block_lock_in  input  LANES  per-lane PHY block lock; asynchronous.
- rx_high_ber_in  input  LANES  per-lane PHY high BER; asynchronous.
- userclk_tx_active  output  1  user-clock-active qualifier to the wizard.
- reset_rx_datapath_out  output  1  RX datapath reset request pulse to the wizard.
- lane_up  output  LANES  lane usable.
- link_up  output  1  all lanes up.
- retry_cnt  output  8  saturating count of RX resets issued.
- state_out  output  3  FSM state encoding, for debug.

Behaviour:
- **Reset:** gt_tx_reset async-clears all flops. While in reset and on the first cycle after it: userclk_tx_active=0, reset_rx_datapath_out=0, lane_up=0, link_up=0, retry_cnt=0, state=ACTIVE_WAIT. Reset mid-operation aborts everything immediately, including a reset pulse in progress.
- **Input sync:** every asynchronous input passes through SYNC_STAGES flops (the *_s signals); all decisions use the synced values.
- **Lane qualification:** per lane, lane_good = lock_s & ~ber_s.
  - Debouncer holds ok[n], 0 after reset.
  - The counter increments while lane_good != ok[n] and clears when they are equal.
  - When the count reaches DEBOUNCE-1 on a qualifying cycle, ok[n] toggles and the counter clears.
  - Debouncers are held cleared (ok=0) in every state except LOCK_WAIT and UP.
- **FSM (encodings 0..5):**
  - ACTIVE_WAIT(0): counts ACTIVE_DELAY cycles, then sets userclk_tx_active=1 (sticky until reset) and goes to TX_WAIT.
  - TX_WAIT(1): waits for tx_done_s=1, then goes to RX_WAIT.
  - RX_WAIT(2): waits for rx_done_s=1, then goes to LOCK_WAIT with the timeout counter cleared.
  - LOCK_WAIT(3): if &ok, go to UP. Otherwise, when the timeout counter reaches LOCK_TIMEOUT-1, go to RX_RST.
  - UP(4): if any ok[n] falls to 0, go to RX_RST.
  - RX_RST(5): reset_rx_datapath_out=1 for exactly RST_PULSE cycles. Then stay with the output at 0 until rx_done_s has been sampled 0 at least once since entering RX_RST, then go to RX_WAIT.
- **Retry counter:** retry_cnt increments on every entry to RX_RST and saturates at 255.
- **Outputs:**
  - lane_up[n] = ok[n] & (state==UP), registered.
  - link_up = &lane_up.
  - reset_rx_datapath_out is registered and glitch-free.
- **Priority:** if tx_done_s=0 in any state from RX_WAIT to RX_RST, go to TX_WAIT. This overrides the lock and timeout transitions and truncates any reset pulse in progress. lane_up drops on the next cycle.
- **Simultaneous events:** in LOCK_WAIT, &ok beats timeout on the same cycle. In UP, a loss on multiple lanes in one cycle produces one RX_RST entry.
- **Latency:** a lock change at the input reaches ok after SYNC_STAGES+DEBOUNCE cycles. lane_up follows ok one cycle later.

Decomposition:
- Package gt_link_pkg holds:
  - the state enum (ACTIVE_WAIT..RX_RST, 3 bits);
  - the retry_cnt width constant (8);
  - the default parameter constants.
- Sub-module lane_lock_debounce (parameters DEBOUNCE, SYNC_STAGES), one instance per lane via generate. Inputs: clk, rst, clr, lock_async, ber_async. Output: ok.
- Synchronizer flops for reset_tx_done_in and reset_rx_done_in live in the top.

Test Plan:
Bench parameters: LANES=2, SYNC_STAGES=2, ACTIVE_DELAY=4, DEBOUNCE=8, LOCK_TIMEOUT=64, RST_PULSE=4.
- **Bring-up:** release reset, tx_done=1 at cycle 10, rx_done=1 at 12, both locks=1 at 15 -> userclk_tx_active rises cycle 4; state 1→2→3→4; lane_up=2'b11 by cycle 15+2+8+1; retry_cnt=0.
- **Lock timeout:** rx_done=1, lane 1 lock held 0 -> after 64 cycles in LOCK_WAIT, reset_rx_datapath_out high exactly 4 cycles; retry_cnt=1. Drop rx_done for 3 cycles -> RX_WAIT.
- **Glitch rejection:** in UP, pulse lane 0 lock low for 5 cycles -> no state change, lane_up stays 11. Hold it low 8 cycles -> RX_RST; lane_up=00.
- **High BER:** in UP, assert rx_high_ber_in[1] for 20 cycles with lock=1 -> RX_RST entered; retry_cnt increments by exactly 1.
- **Priority and abort:** in RX_RST, drop tx_done -> TX_WAIT within SYNC_STAGES+1 cycles; reset pulse stops. Assert gt_tx_reset mid-UP -> all outputs 0 asynchronously; retry_cnt=0.
- **Saturation:** force 300 timeouts -> retry_cnt holds at 255.

Source files
------------

// File: rtl/gt_link_sequencer_pkg.sv
// gt_link_pkg: shared types and constants for the GT link sequencer.
//   link_state_e : sequencer FSM states (3-bit encoding, exported as state_out)
//   RETRY_W      : width of the saturating RX-reset retry counter
//   DEF_*        : default parameter values used by the sequencer modules
//   sat_inc      : saturating increment for the retry counter
package gt_link_pkg;

  typedef enum logic [2:0] {
    ACTIVE_WAIT = 3'd0,
    TX_WAIT     = 3'd1,
    RX_WAIT     = 3'd2,
    LOCK_WAIT   = 3'd3,
    UP          = 3'd4,
    RX_RST      = 3'd5
  } link_state_e;

  localparam int RETRY_W = 8;

  localparam int DEF_LANES        = 2;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_ACTIVE_DELAY = 8;
  localparam int DEF_DEBOUNCE     = 1024;
  localparam int DEF_LOCK_TIMEOUT = 1048576;
  localparam int DEF_RST_PULSE    = 16;

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (&v) ? v : v + RETRY_W'(1);
  endfunction

endpackage

// File: rtl/gt_link_sequencer_if.sv
// gt_link_sequencer_if: wizard/PHY status and sequencer control bundle.
//   reset_tx_done_in, reset_rx_done_in : wizard reset-done status (async)
//   rx_block_lock_in, rx_high_ber_in   : per-lane PHY status (async)
//   userclk_tx_active, reset_rx_datapath_out : controls back to the wizard
//   lane_up, link_up, retry_cnt, state_out   : link health to the core/debug
// Modports: master = wizard/PHY side (drives status), slave = sequencer.
interface gt_link_sequencer_if
  import gt_link_pkg::*;
#(
  parameter int LANES = DEF_LANES
);
  logic                   reset_tx_done_in;
  logic                   reset_rx_done_in;
  logic [LANES-1:0]       rx_block_lock_in;
  logic [LANES-1:0]       rx_high_ber_in;
  logic                   userclk_tx_active;
  logic                   reset_rx_datapath_out;
  logic [LANES-1:0]       lane_up;
  logic                   link_up;
  logic [RETRY_W-1:0]     retry_cnt;
  logic [2:0]             state_out;

  modport master (
    output reset_tx_done_in, reset_rx_done_in, rx_block_lock_in, rx_high_ber_in,
    input  userclk_tx_active, reset_rx_datapath_out, lane_up, link_up, retry_cnt, state_out
  );

  modport slave (
    input  reset_tx_done_in, reset_rx_done_in, rx_block_lock_in, rx_high_ber_in,
    output userclk_tx_active, reset_rx_datapath_out, lane_up, link_up, retry_cnt, state_out
  );
endinterface

// File: rtl/gt_link_sequencer_lane_lock_debounce.sv
// lane_lock_debounce: synchronises one lane's block-lock and high-BER status
// and debounces lane_good = lock & ~ber into a stable ok flag.
//   clk, rst   : user clock, async active-high reset
//   clr        : holds the debouncer cleared (ok=0, count=0)
//   lock_async : PHY block lock, asynchronous
//   ber_async  : PHY high BER, asynchronous
//   ok         : debounced lane status
module lane_lock_debounce
  import gt_link_pkg::*;
#(
  parameter int DEBOUNCE    = DEF_DEBOUNCE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic lock_async,
  input  logic ber_async,
  output logic ok
);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  logic [SYNC_STAGES-1:0] ber_sync_q, ber_sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ok_q, ok_d;
  logic                   lane_good;

  always_comb begin
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], lock_async};
    ber_sync_d  = {ber_sync_q[SYNC_STAGES-2:0], ber_async};
    lane_good   = lock_sync_q[SYNC_STAGES-1] & ~ber_sync_q[SYNC_STAGES-1];
    ok_d        = ok_q;
    cnt_d       = '0;
    // The count measures consecutive cycles of disagreement; any cycle of
    // agreement restarts it, so only a sustained change flips ok.
    if (clr) begin
      ok_d = 1'b0;
    end else if (lane_good != ok_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE - 1)) ok_d = ~ok_q;
      else                               cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_sync_q <= '0;
      ber_sync_q  <= '0;
      cnt_q       <= '0;
      ok_q        <= 1'b0;
    end else begin
      lock_sync_q <= lock_sync_d;
      ber_sync_q  <= ber_sync_d;
      cnt_q       <= cnt_d;
      ok_q        <= ok_d;
    end
  end

  assign ok = ok_q;

endmodule

// File: rtl/gt_link_sequencer.sv
// gt_link_sequencer: GT transceiver bring-up and link-health supervisor in
// the TX user-clock domain.
//   gt_txusrclk : TX user clock
//   gt_tx_reset : async active-high reset, clears every flop
//   lnk (slave) : wizard reset-done / PHY lane status in; userclk_tx_active,
//                 reset_rx_datapath_out, lane_up, link_up, retry_cnt and
//                 state_out (FSM encoding for debug) out.
// Bring-up: wait ACTIVE_DELAY cycles, raise userclk_tx_active, wait TX then
// RX reset done, then wait for all lanes to debounce good. Lock timeout or a
// lane loss pulses reset_rx_datapath_out and restarts from RX_WAIT.
module gt_link_sequencer
  import gt_link_pkg::*;
#(
  parameter int LANES        = DEF_LANES,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int ACTIVE_DELAY = DEF_ACTIVE_DELAY,
  parameter int DEBOUNCE     = DEF_DEBOUNCE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int RST_PULSE    = DEF_RST_PULSE
) (
  input  logic               gt_txusrclk,
  input  logic               gt_tx_reset,
  gt_link_sequencer_if.slave lnk
);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] tx_sync_q, tx_sync_d;
  logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
  logic                   tx_done_s, rx_done_s;
  logic [LANES-1:0]       ok;
  logic                   deb_clr;

  link_state_e            state_q, state_d;
  logic [7:0]             act_cnt_q, act_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [7:0]             pulse_cnt_q, pulse_cnt_d;
  logic                   active_q, active_d;
  logic                   rst_out_q, rst_out_d;
  logic                   rx_seen0_q, rx_seen0_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [LANES-1:0]       lane_up_q, lane_up_d;
  logic                   enter_rst;
  logic                   tx_lost;

  always_comb begin
    tx_sync_d = {tx_sync_q[SYNC_STAGES-2:0], lnk.reset_tx_done_in};
    rx_sync_d = {rx_sync_q[SYNC_STAGES-2:0], lnk.reset_rx_done_in};
  end

  assign tx_done_s = tx_sync_q[SYNC_STAGES-1];
  assign rx_done_s = rx_sync_q[SYNC_STAGES-1];

  // Debouncers only run while the link is trying to come up or is up, so
  // every LOCK_WAIT attempt starts from a clean "not ok" state.
  assign deb_clr = !(state_q == LOCK_WAIT || state_q == UP);

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    lane_lock_debounce #(
      .DEBOUNCE    (DEBOUNCE),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_deb (
      .clk        (gt_txusrclk),
      .rst        (gt_tx_reset),
      .clr        (deb_clr),
      .lock_async (lnk.rx_block_lock_in[n]),
      .ber_async  (lnk.rx_high_ber_in[n]),
      .ok         (ok[n])
    );
  end

  assign tx_lost = !tx_done_s &&
                   (state_q inside {RX_WAIT, LOCK_WAIT, UP, RX_RST});

  always_comb begin
    state_d     = state_q;
    act_cnt_d   = act_cnt_q;
    to_cnt_d    = '0;
    pulse_cnt_d = pulse_cnt_q;
    active_d    = active_q;
    rst_out_d   = 1'b0;
    rx_seen0_d  = rx_seen0_q;
    retry_d     = retry_q;
    enter_rst   = 1'b0;

    case (state_q)
      ACTIVE_WAIT: begin
        if (act_cnt_q == 8'(ACTIVE_DELAY - 1)) begin
          active_d = 1'b1;
          state_d  = TX_WAIT;
        end else begin
          act_cnt_d = act_cnt_q + 8'd1;
        end
      end
      TX_WAIT: begin
        if (tx_done_s) state_d = RX_WAIT;
      end
      RX_WAIT: begin
        if (rx_done_s) state_d = LOCK_WAIT;
      end
      LOCK_WAIT: begin
        // All-lanes-ok is checked first so it wins over a coincident timeout.
        if (&ok)                                     state_d   = UP;
        else if (to_cnt_q == TO_W'(LOCK_TIMEOUT - 1)) enter_rst = 1'b1;
        else                                         to_cnt_d  = to_cnt_q + TO_W'(1);
      end
      UP: begin
        // Any number of lanes dropping together is a single retry.
        if (!(&ok)) enter_rst = 1'b1;
      end
      RX_RST: begin
        if (!rx_done_s) rx_seen0_d = 1'b1;
        if (rst_out_q) begin
          if (pulse_cnt_q != 8'(RST_PULSE - 1)) begin
            rst_out_d   = 1'b1;
            pulse_cnt_d = pulse_cnt_q + 8'd1;
          end
        end else if (rx_seen0_q || !rx_done_s) begin
          // The wizard must be seen leaving "RX done" before the new
          // reset-done can be trusted.
          state_d = RX_WAIT;
        end
      end
      default: state_d = ACTIVE_WAIT;
    endcase

    // Losing TX reset-done trumps everything, including a pulse in flight.
    if (tx_lost) begin
      state_d   = TX_WAIT;
      rst_out_d = 1'b0;
    end else if (enter_rst) begin
      state_d     = RX_RST;
      rst_out_d   = 1'b1;
      pulse_cnt_d = '0;
      rx_seen0_d  = 1'b0;
      retry_d     = sat_inc(retry_q);
    end

    lane_up_d = ok & {LANES{state_d == UP}};
  end

  always_ff @(posedge gt_txusrclk or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      tx_sync_q   <= '0;
      rx_sync_q   <= '0;
      state_q     <= ACTIVE_WAIT;
      act_cnt_q   <= '0;
      to_cnt_q    <= '0;
      pulse_cnt_q <= '0;
      active_q    <= 1'b0;
      rst_out_q   <= 1'b0;
      rx_seen0_q  <= 1'b0;
      retry_q     <= '0;
      lane_up_q   <= '0;
    end else begin
      tx_sync_q   <= tx_sync_d;
      rx_sync_q   <= rx_sync_d;
      state_q     <= state_d;
      act_cnt_q   <= act_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      active_q    <= active_d;
      rst_out_q   <= rst_out_d;
      rx_seen0_q  <= rx_seen0_d;
      retry_q     <= retry_d;
      lane_up_q   <= lane_up_d;
    end
  end

  assign lnk.userclk_tx_active     = active_q;
  assign lnk.reset_rx_datapath_out = rst_out_q;
  assign lnk.lane_up               = lane_up_q;
  assign lnk.link_up               = &lane_up_q;
  assign lnk.retry_cnt             = retry_q;
  assign lnk.state_out             = state_q;

endmodule

// File: tb/tb_gt_link_sequencer.sv
// Testbench for gt_link_sequencer: directed bring-up, timeout, glitch, BER,
// priority, reset-abort and saturation scenarios, checked every cycle
// against a behavioural model plus pinned literal expectations.
module tb_gt_link_sequencer;
  import gt_link_pkg::*;

  localparam int LANES        = 2;
  localparam int SYNC_STAGES  = 2;
  localparam int ACTIVE_DELAY = 4;
  localparam int DEBOUNCE     = 8;
  localparam int LOCK_TIMEOUT = 64;
  localparam int RST_PULSE    = 4;

  logic clk = 1'b0;
  logic rst;

  gt_link_sequencer_if #(.LANES(LANES)) lnk ();

  gt_link_sequencer #(
    .LANES        (LANES),
    .SYNC_STAGES  (SYNC_STAGES),
    .ACTIVE_DELAY (ACTIVE_DELAY),
    .DEBOUNCE     (DEBOUNCE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .RST_PULSE    (RST_PULSE)
  ) dut (
    .gt_txusrclk (clk),
    .gt_tx_reset (rst),
    .lnk         (lnk)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State is tracked as a plain number plus "cycles spent in this state";
  // synced inputs are the raw inputs delayed by SYNC_STAGES clock edges.
  int               m_state, m_age, m_retry, m_entries;
  bit               m_active, m_rst_out, m_seen0;
  bit [LANES-1:0]   m_ok, m_lane_up;
  int               m_run [LANES];
  bit               tx_h [SYNC_STAGES];
  bit               rx_h [SYNC_STAGES];
  bit [LANES-1:0]   lk_h [SYNC_STAGES];
  bit [LANES-1:0]   ber_h [SYNC_STAGES];

  task automatic model_reset();
    m_state = 0; m_age = 0; m_retry = 0; m_entries = 0;
    m_active = 0; m_rst_out = 0; m_seen0 = 0;
    m_ok = '0; m_lane_up = '0;
    for (int n = 0; n < LANES; n++) m_run[n] = 0;
    for (int i = 0; i < SYNC_STAGES; i++) begin
      tx_h[i] = 0; rx_h[i] = 0; lk_h[i] = '0; ber_h[i] = '0;
    end
  endtask

  task automatic model_step();
    bit             tx_s, rx_s, enter_rst;
    bit [LANES-1:0] lk_s, ber_s, good, ok_old;
    int             nxt, age_new;
    tx_s  = tx_h[SYNC_STAGES-1];
    rx_s  = rx_h[SYNC_STAGES-1];
    lk_s  = lk_h[SYNC_STAGES-1];
    ber_s = ber_h[SYNC_STAGES-1];
    for (int i = SYNC_STAGES - 1; i > 0; i--) begin
      tx_h[i] = tx_h[i-1]; rx_h[i] = rx_h[i-1]; lk_h[i] = lk_h[i-1]; ber_h[i] = ber_h[i-1];
    end
    tx_h[0]  = lnk.reset_tx_done_in;
    rx_h[0]  = lnk.reset_rx_done_in;
    lk_h[0]  = lnk.rx_block_lock_in;
    ber_h[0] = lnk.rx_high_ber_in;

    good   = lk_s & ~ber_s;
    ok_old = m_ok;
    for (int n = 0; n < LANES; n++) begin
      if (!(m_state == 3 || m_state == 4)) begin
        m_ok[n] = 0; m_run[n] = 0;
      end else if (good[n] != m_ok[n]) begin
        m_run[n]++;
        if (m_run[n] == DEBOUNCE) begin m_ok[n] = ~m_ok[n]; m_run[n] = 0; end
      end else begin
        m_run[n] = 0;
      end
    end

    nxt = m_state; enter_rst = 0;
    if (m_state == 0) begin
      if (m_age == ACTIVE_DELAY - 1) begin m_active = 1; nxt = 1; end
    end else if (m_state == 1) begin
      if (tx_s) nxt = 2;
    end else if (!tx_s) begin
      nxt = 1;
    end else if (m_state == 2) begin
      if (rx_s) nxt = 3;
    end else if (m_state == 3) begin
      if (&ok_old) nxt = 4;
      else if (m_age == LOCK_TIMEOUT - 1) enter_rst = 1;
    end else if (m_state == 4) begin
      if (!(&ok_old)) enter_rst = 1;
    end else begin
      if (!rx_s) m_seen0 = 1;
      if (m_age >= RST_PULSE && m_seen0) nxt = 2;
    end
    if (enter_rst) begin
      nxt = 5; m_seen0 = 0; m_entries++;
      if (m_retry < 255) m_retry++;
    end
    age_new   = (nxt == m_state) ? m_age + 1 : 0;
    m_rst_out = (nxt == 5) && (age_new < RST_PULSE);
    m_lane_up = (nxt == 4) ? ok_old : '0;
    m_state   = nxt;
    m_age     = age_new;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  function automatic logic [31:0] dut_vec();
    return 32'({lnk.userclk_tx_active, lnk.reset_rx_datapath_out, lnk.lane_up,
                lnk.link_up, lnk.retry_cnt, lnk.state_out});
  endfunction

  function automatic logic [31:0] model_vec();
    logic [7:0] r;
    logic [2:0] s;
    r = 8'(m_retry);
    s = 3'(m_state);
    return 32'({m_active, m_rst_out, m_lane_up, &m_lane_up, r, s});
  endfunction

  // Every-cycle comparison against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("model_outputs", dut_vec(), model_vec());
    end
  end

  // ---------------- stimulus ----------------
  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int bound, input string name);
    int n = 0;
    while (lnk.state_out != 3'(s) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(lnk.state_out), 32'(s));
  endtask

  task automatic rx_drop3();
    lnk.reset_rx_done_in = 1'b0;
    repeat (3) @(negedge clk);
    lnk.reset_rx_done_in = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    lnk.reset_tx_done_in = 1'b0;
    lnk.reset_rx_done_in = 1'b0;
    lnk.rx_block_lock_in = '0;
    lnk.rx_high_ber_in   = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", dut_vec(), 32'h0);
    rst = 1'b0;

    // Bring-up
    to_cyc(1);  chk("first_cycle_state", 32'(lnk.state_out), 32'd0);
    to_cyc(3);  chk("active_before", 32'(lnk.userclk_tx_active), 32'd0);
    to_cyc(4);  chk("active_rise", 32'(lnk.userclk_tx_active), 32'd1);
                chk("tx_wait_state", 32'(lnk.state_out), 32'd1);
    to_cyc(9);  lnk.reset_tx_done_in = 1'b1;
    to_cyc(11); lnk.reset_rx_done_in = 1'b1;
    to_cyc(12); chk("rx_wait_state", 32'(lnk.state_out), 32'd2);
    to_cyc(14); chk("lock_wait_state", 32'(lnk.state_out), 32'd3);
                lnk.rx_block_lock_in = 2'b11;
    to_cyc(24); chk("lane_up_not_yet", 32'(lnk.lane_up), 32'd0);
    to_cyc(25); chk("lane_up_both", 32'(lnk.lane_up), 32'd3);
                chk("up_state", 32'(lnk.state_out), 32'd4);
                chk("link_up", 32'(lnk.link_up), 32'd1);
                chk("retry_zero", 32'(lnk.retry_cnt), 32'd0);

    // Glitch rejection: 5 low cycles are filtered, 8+ are not
    to_cyc(30); lnk.rx_block_lock_in[0] = 1'b0;
    to_cyc(35); lnk.rx_block_lock_in[0] = 1'b1;
    to_cyc(50); chk("glitch_lane_up", 32'(lnk.lane_up), 32'd3);
                chk("glitch_state", 32'(lnk.state_out), 32'd4);
                lnk.rx_block_lock_in[0] = 1'b0;
    to_cyc(60); chk("loss_pending_state", 32'(lnk.state_out), 32'd4);
    to_cyc(61); chk("loss_rx_rst", 32'(lnk.state_out), 32'd5);
                chk("loss_lane_up", 32'(lnk.lane_up), 32'd0);
                chk("loss_pulse_on", 32'(lnk.reset_rx_datapath_out), 32'd1);
                chk("loss_retry", 32'(lnk.retry_cnt), 32'd1);
    to_cyc(64); chk("pulse_last", 32'(lnk.reset_rx_datapath_out), 32'd1);
    to_cyc(65); chk("pulse_end", 32'(lnk.reset_rx_datapath_out), 32'd0);
                chk("hold_rx_rst", 32'(lnk.state_out), 32'd5);
                lnk.rx_block_lock_in[0] = 1'b1;
    rx_drop3();
    wait_state(4, 60, "recover_up_1");

    // High BER on lane 1 with lock held
    lnk.rx_high_ber_in[1] = 1'b1;
    repeat (20) @(negedge clk);
    chk("ber_state", 32'(lnk.state_out), 32'd5);
    chk("ber_retry", 32'(lnk.retry_cnt), 32'd2);
    lnk.rx_high_ber_in[1] = 1'b0;

    // Lock timeout with lane 1 never locking
    lnk.rx_block_lock_in[1] = 1'b0;
    rx_drop3();
    wait_state(3, 40, "enter_lock_wait");
    n = 0;
    while (lnk.state_out == 3'd3 && n < 200) begin n++; @(negedge clk); end
    chk("lock_wait_cycles", 32'(n), 32'd64);
    chk("timeout_rx_rst", 32'(lnk.state_out), 32'd5);
    chk("timeout_retry", 32'(lnk.retry_cnt), 32'd3);
    n = 0;
    while (lnk.reset_rx_datapath_out && n < 50) begin n++; @(negedge clk); end
    chk("pulse_width", 32'(n), 32'd4);
    rx_drop3();
    wait_state(2, 20, "back_to_rx_wait");

    // Priority: TX reset-done lost mid pulse
    wait_state(5, 200, "second_timeout");
    lnk.reset_tx_done_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("prio_tx_wait", 32'(lnk.state_out), 32'd1);
    chk("prio_pulse_cut", 32'(lnk.reset_rx_datapath_out), 32'd0);
    chk("prio_retry", 32'(lnk.retry_cnt), 32'd4);
    lnk.reset_tx_done_in = 1'b1;
    lnk.rx_block_lock_in = 2'b11;
    wait_state(4, 100, "recover_up_2");

    // Asynchronous reset in UP
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", dut_vec(), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Saturation: repeated lock timeouts
    lnk.rx_block_lock_in[1] = 1'b0;
    for (int k = 0; k < 40000 && m_entries < 300; k++) begin
      lnk.reset_rx_done_in = ((k % 16) >= 4);
      @(negedge clk);
    end
    chk("timeouts_reached", 32'(m_entries >= 300), 32'd1);
    chk("retry_saturated", 32'(lnk.retry_cnt), 32'd255);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
